forward_stall_ctrl: RTL and testbench
=====================================

FORWARD_STALL_CTRL -- requirements
Module: forward_stall_ctrl

Interface
REQ-001 The block SHALL have parameter NSRC, default 2: number of decode-stage source operands checked.
REQ-002 The block SHALL have parameter RA_W, default 5: register address width.
REQ-003 The block SHALL have parameter MAX_STALL, default 16, range 2..255: consecutive-stall limit before timeout.
REQ-004 The block SHALL have parameter STAT_W, default 16: stall statistics counter width.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have the following ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- d_rs  in  NSRC*RA_W  decode source register numbers; operand i is bits [i*RA_W +: RA_W]
- d_use  in  NSRC  operand i is actually read
- e_wreg, e_m2reg  in  1 each  EXE instruction writes a register / is a load
- e_rn  in  RA_W  EXE destination register
- m_wreg, m_m2reg  in  1 each  MEM instruction writes a register / is a load
- m_rn  in  RA_W  MEM destination register
- m_ld_valid  in  1  MEM load data available this cycle
- stat_clr  in  1  synchronous clear of statistics
- fwd  out  NSRC*2  per-operand forward select; operand i is bits [2i +: 2]
- stall  out  1  freeze PC and IF/ID, inject bubble into EXE
- state  out  2  FSM state
- stall_total  out  STAT_W  saturating count of stall cycles
- stall_timeout  out  1  sticky watchdog flag

Function
REQ-007 An operand i SHALL be "live" when d_use[i]=1 and its register number is not 0.
REQ-008 fwd[i] SHALL be combinational and evaluated in priority order:
- 01: live, e_wreg=1, e_m2reg=0, e_rn equals the operand register (EXE ALU result).
- else 10: live, m_wreg=1, m_m2reg=0, m_rn equals the operand register (MEM ALU result).
- else 11: live, m_wreg=1, m_m2reg=1, m_rn equals the operand register (MEM load data).
- else 00: register file.
REQ-009 lu_hit SHALL be combinational: any live operand with e_wreg=1, e_m2reg=1 and e_rn equal to the operand register.
REQ-010 mw_hit SHALL be combinational: any live operand whose fwd select is 11 while m_ld_valid=0.
REQ-011 stall SHALL equal lu_hit OR mw_hit combinationally, with no cycle latency.
REQ-012 The FSM state register SHALL use encoding RUN=00, LU=01, MW=10; 11 is unused and SHALL recover to RUN on the next edge.
REQ-013 The next state SHALL be MW if mw_hit, else LU if lu_hit, else RUN; it updates every rising edge, and mw_hit takes precedence when both hits are true.
REQ-014 The state output SHALL reflect the registered state, which is the reason for the previous cycle's stall.
REQ-015 The run_len register (internal, width ceil(log2(MAX_STALL+1))) SHALL behave as follows on each edge:
- stall=1: run_len increments, saturating at MAX_STALL.
- stall=0: run_len becomes 0.
REQ-016 stall_timeout SHALL set on the edge where stall=1 and run_len=MAX_STALL-1, i.e. the MAX_STALL-th consecutive stall cycle; it stays set until reset and is unaffected by stat_clr.
REQ-017 stall_total SHALL update on each edge as follows:
- stat_clr=1: becomes 0; clear wins over a simultaneous increment.
- otherwise, stall=1: increments by 1, saturating at 2^STAT_W-1 with no wrap.
REQ-018 Inputs SHALL NOT be registered; fwd and stall SHALL be valid in the same cycle their inputs are.

Reset
REQ-019 While reset=1, state SHALL be 00, run_len 0, stall_total 0 and stall_timeout 0, asynchronously.
REQ-020 fwd and stall SHALL remain purely combinational during reset.
REQ-021 Reset asserted during a stall run SHALL discard the run length; counting restarts from 0 after release.

Verification
REQ-022 The bench SHALL cover the forward priority case:
- stimulus: d_rs={5,5}, d_use=11, e_wreg=1, e_m2reg=0, e_rn=5, m_wreg=1, m_m2reg=0, m_rn=5
- required response: fwd=0101, stall=0
- then e_wreg=0: fwd=1010.
REQ-023 The bench SHALL cover register zero and unused operands:
- stimulus: d_rs={0,7}, d_use=01 (operand 0 = register 7, used; operand 1 = register 0), e_wreg=1, e_rn=0, m_rn=7, m_wreg=1, m_m2reg=0
- required response: fwd=0010; with d_use=00, fwd=0000.
REQ-024 The bench SHALL cover a load-use hazard:
- stimulus: operand 0 = register 3, e_wreg=1, e_m2reg=1, e_rn=3 for one cycle
- required response: stall=1 that cycle; state=01 after the edge
- next cycle, with the load in MEM, m_ld_valid=1: stall=0, fwd[1:0]=11; stall_total=1.
REQ-025 The bench SHALL cover a slow load:
- stimulus: m_wreg=1, m_m2reg=1, m_rn=4, operand 1 = register 4, m_ld_valid=0 for 3 cycles, then 1
- required response: stall=1 for 3 cycles, state=10 during that interval, stall_total=3; stall drops in the same cycle m_ld_valid rises.
REQ-026 The bench SHALL cover the watchdog:
- stimulus: hold mw_hit for 16 cycles with MAX_STALL=16
- required response: stall_timeout=1 after the 16th edge, not after the 15th
- it stays 1 after stall clears and after stat_clr; only reset clears it.
REQ-027 The bench SHALL cover clear, saturation and reset:
- stimulus: STAT_W=4, hold stall 20 cycles
- required response: stall_total=15
- stat_clr with stall=1 gives 0; asserting reset mid-stall asynchronously gives state=00 and stall_total=0.

Source files
------------

// File: rtl/forward_stall_ctrl.sv
// rtl/forward_stall_ctrl.sv - operand forwarding select, load hazard stall and stall watchdog
//
// Purpose: picks a forward source for each decode-stage operand and freezes
// the front of the pipe on load-use and slow-load hazards. It also keeps a
// saturating stall-cycle count and a sticky timeout flag.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   d_rs, d_use    decode operand register numbers (RA_W each) and read enables
//   e_wreg/e_m2reg/e_rn    EXE stage write-enable, is-load, destination
//   m_wreg/m_m2reg/m_rn    MEM stage write-enable, is-load, destination
//   m_ld_valid     MEM load data available this cycle
//   stat_clr       synchronous clear of stall_total
//   fwd            2-bit forward select per operand (00 rf, 01 exe, 10 mem alu, 11 mem load)
//   stall          combinational pipeline freeze
//   state          registered reason for the previous cycle's stall (00 run, 01 lu, 10 mw)
//   stall_total    saturating stall-cycle count
//   stall_timeout  sticky flag, set on the MAX_STALL-th consecutive stall cycle
module forward_stall_ctrl #(
    parameter int NSRC      = 2,
    parameter int RA_W      = 5,
    parameter int MAX_STALL = 16,
    parameter int STAT_W    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NSRC*RA_W-1:0]   d_rs,
    input  logic [NSRC-1:0]        d_use,
    input  logic                   e_wreg,
    input  logic                   e_m2reg,
    input  logic [RA_W-1:0]        e_rn,
    input  logic                   m_wreg,
    input  logic                   m_m2reg,
    input  logic [RA_W-1:0]        m_rn,
    input  logic                   m_ld_valid,
    input  logic                   stat_clr,
    output logic [NSRC*2-1:0]      fwd,
    output logic                   stall,
    output logic [1:0]             state,
    output logic [STAT_W-1:0]      stall_total,
    output logic                   stall_timeout
);

    localparam int RL_W = $clog2(MAX_STALL + 1);
    localparam logic [RL_W-1:0] RL_MAX  = RL_W'(MAX_STALL);
    localparam logic [RL_W-1:0] RL_TRIP = RL_W'(MAX_STALL - 1);

    typedef enum logic [1:0] {
        RUN = 2'b00,
        LU  = 2'b01,
        MW  = 2'b10
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [RL_W-1:0] run_len;
    logic            lu_hit;
    logic            mw_hit;

    always_comb begin
        logic [RA_W-1:0] rs;
        logic            live;
        fwd    = '0;
        lu_hit = 1'b0;
        mw_hit = 1'b0;
        rs     = '0;
        live   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            rs   = d_rs[i*RA_W +: RA_W];
            // Register 0 is hardwired, so it never needs forwarding or a stall.
            live = d_use[i] && (rs != '0);
            if (live && e_wreg && !e_m2reg && (e_rn == rs)) begin
                fwd[2*i +: 2] = 2'b01;
            end else if (live && m_wreg && !m_m2reg && (m_rn == rs)) begin
                fwd[2*i +: 2] = 2'b10;
            end else if (live && m_wreg && m_m2reg && (m_rn == rs)) begin
                fwd[2*i +: 2] = 2'b11;
                if (!m_ld_valid) begin
                    mw_hit = 1'b1;
                end
            end
            // A load still in EXE has no data yet: the consumer must wait a cycle.
            if (live && e_wreg && e_m2reg && (e_rn == rs)) begin
                lu_hit = 1'b1;
            end
        end
    end

    assign stall = lu_hit | mw_hit;
    assign state = state_q;

    // Next state depends only on the hits, so the unused encoding 11 falls
    // back to RUN on the following edge without special handling.
    always_comb begin
        state_d = RUN;
        if (mw_hit) begin
            state_d = MW;
        end else if (lu_hit) begin
            state_d = LU;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            run_len       <= '0;
            stall_total   <= '0;
            stall_timeout <= 1'b0;
        end else begin
            state_q <= state_d;

            if (stall) begin
                if (run_len != RL_MAX) begin
                    run_len <= run_len + 1'b1;
                end
            end else begin
                run_len <= '0;
            end

            if (stall && (run_len == RL_TRIP)) begin
                stall_timeout <= 1'b1;
            end

            if (stat_clr) begin
                stall_total <= '0;
            end else if (stall && (stall_total != {STAT_W{1'b1}})) begin
                stall_total <= stall_total + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_forward_stall_ctrl.sv
// tb/tb_forward_stall_ctrl.sv - directed self-checking bench for forward_stall_ctrl
module tb_forward_stall_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  d_rs;
    logic [1:0]  d_use;
    logic        e_wreg, e_m2reg;
    logic [4:0]  e_rn;
    logic        m_wreg, m_m2reg;
    logic [4:0]  m_rn;
    logic        m_ld_valid;
    logic        stat_clr;
    logic [3:0]  fwd;
    logic        stall;
    logic [1:0]  state;
    logic [3:0]  stall_total;
    logic        stall_timeout;

    int checks = 0;
    int errors = 0;

    forward_stall_ctrl #(
        .NSRC(2), .RA_W(5), .MAX_STALL(16), .STAT_W(4)
    ) dut (
        .clock(clock), .reset(reset),
        .d_rs(d_rs), .d_use(d_use),
        .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn),
        .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn),
        .m_ld_valid(m_ld_valid), .stat_clr(stat_clr),
        .fwd(fwd), .stall(stall), .state(state),
        .stall_total(stall_total), .stall_timeout(stall_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        d_rs = '0; d_use = '0;
        e_wreg = 0; e_m2reg = 0; e_rn = '0;
        m_wreg = 0; m_m2reg = 0; m_rn = '0;
        m_ld_valid = 0; stat_clr = 0;
    endtask

    // Operand 1 reads r4 while a load to r4 sits in MEM with no data.
    task automatic slow_load();
        idle();
        d_rs = {5'd4, 5'd0}; d_use = 2'b10;
        m_wreg = 1; m_m2reg = 1; m_rn = 5'd4; m_ld_valid = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        chk("rst_state", state, 2'b00);
        chk("rst_total", stall_total, 4'd0);
        chk("rst_timeout", stall_timeout, 1'b0);

        // Forward priority, evaluated while reset is still held.
        d_rs = {5'd5, 5'd5}; d_use = 2'b11;
        e_wreg = 1; e_m2reg = 0; e_rn = 5'd5;
        m_wreg = 1; m_m2reg = 0; m_rn = 5'd5;
        #1;
        chk("prio_exe_fwd", fwd, 4'b0101);
        chk("prio_exe_stall", stall, 1'b0);
        e_wreg = 0;
        #1;
        chk("prio_mem_fwd", fwd, 4'b1010);
        tick();
        chk("rst_hold_state", state, 2'b00);
        reset = 1'b0;

        // Register zero and unused operands.
        idle();
        d_rs = {5'd0, 5'd7}; d_use = 2'b01;
        e_wreg = 1; e_rn = 5'd0;
        m_wreg = 1; m_m2reg = 0; m_rn = 5'd7;
        #1;
        chk("r0_fwd", fwd, 4'b0010);
        d_use = 2'b11;
        #1;
        chk("r0_used_fwd", fwd, 4'b0010);
        d_use = 2'b00;
        #1;
        chk("unused_fwd", fwd, 4'b0000);
        chk("unused_stall", stall, 1'b0);
        tick();
        chk("idle_state", state, 2'b00);
        chk("idle_total", stall_total, 4'd0);

        // Load-use hazard followed by MEM load forwarding.
        idle();
        d_rs = {5'd0, 5'd3}; d_use = 2'b01;
        e_wreg = 1; e_m2reg = 1; e_rn = 5'd3;
        #1;
        chk("lu_stall", stall, 1'b1);
        chk("lu_fwd", fwd, 4'b0000);
        tick();
        chk("lu_state", state, 2'b01);
        e_wreg = 0; e_m2reg = 0;
        m_wreg = 1; m_m2reg = 1; m_rn = 5'd3; m_ld_valid = 1;
        #1;
        chk("lu_mem_stall", stall, 1'b0);
        chk("lu_mem_fwd", fwd[1:0], 2'b11);
        chk("lu_total", stall_total, 4'd1);
        tick();
        chk("lu_done_state", state, 2'b00);

        // Slow load: three stall cycles, release in the cycle data arrives.
        idle();
        stat_clr = 1;
        tick();
        stat_clr = 0;
        chk("clr_total", stall_total, 4'd0);
        slow_load();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mw_stall", stall, 1'b1);
            chk("mw_fwd", fwd, 4'b1100);
            tick();
            chk("mw_state", state, 2'b10);
        end
        chk("mw_total", stall_total, 4'd3);
        m_ld_valid = 1;
        #1;
        chk("mw_release_stall", stall, 1'b0);
        tick();
        chk("mw_release_state", state, 2'b00);

        // Both hazards at once: slow load takes precedence.
        slow_load();
        d_rs = {5'd4, 5'd3}; d_use = 2'b11;
        e_wreg = 1; e_m2reg = 1; e_rn = 5'd3;
        #1;
        chk("both_stall", stall, 1'b1);
        tick();
        chk("both_state", state, 2'b10);
        chk("both_total", stall_total, 4'd4);
        idle();
        stat_clr = 1;
        tick();
        stat_clr = 0;
        chk("both_clr_total", stall_total, 4'd0);

        // Watchdog and counter saturation over a 20-cycle stall run.
        slow_load();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15) chk("wd_15", stall_timeout, 1'b0);
            if (k == 16) chk("wd_16", stall_timeout, 1'b1);
        end
        chk("sat_total", stall_total, 4'd15);
        stat_clr = 1;
        tick();
        chk("clr_wins_total", stall_total, 4'd0);
        chk("clr_keeps_timeout", stall_timeout, 1'b1);
        stat_clr = 0;
        tick();
        chk("post_clr_total", stall_total, 4'd1);
        idle();
        tick();
        chk("nostall_timeout", stall_timeout, 1'b1);
        chk("nostall_state", state, 2'b00);

        // Asynchronous reset in the middle of a stall run.
        slow_load();
        tick();
        tick();
        chk("pre_rst_state", state, 2'b10);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", state, 2'b00);
        chk("arst_total", stall_total, 4'd0);
        chk("arst_timeout", stall_timeout, 1'b0);
        chk("arst_stall_comb", stall, 1'b1);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) chk("rerun_wd_15", stall_timeout, 1'b0);
            if (k == 16) chk("rerun_wd_16", stall_timeout, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
